// File: rtl/mem_loader_pkg.sv
// Shared definitions for the boot-memory loader.
//   - Command bytes of the host boot protocol ('a', 'd', 'j') and the default ack byte.
//   - Loader FSM state encoding.
//   - word_in_range(): legality check for a byte pointer against the target memory.
package mem_loader_pkg;

  localparam logic [7:0] CMD_ADDR         = 8'h61;  // 'a': set address / jump target
  localparam logic [7:0] CMD_DATA         = 8'h64;  // 'd': write one word
  localparam logic [7:0] CMD_JUMP         = 8'h6A;  // 'j': release the CPU
  localparam logic [7:0] ACK_BYTE_DEFAULT = 8'h66;  // 'f'

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StGetAddr = 3'd1,
    StGetData = 3'd2,
    StWrite   = 3'd3,
    StAck     = 3'd4,
    StRun     = 3'd5
  } state_e;

  // A byte pointer is writable when it is word aligned and its word index fits
  // in addr_w bits.
  function automatic logic word_in_range(input logic [31:0] ptr, input int unsigned addr_w);
    logic [31:0] upper;
    upper = ptr >> (addr_w + 2);
    return (upper == 32'd0) && (ptr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/mem_loader_byte_assembler.sv
// Collects four bytes MSB-first into a 32-bit word.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   clear_i        : drop any partially collected word
//   byte_i/valid_i : incoming byte and its strobe
//   word_o         : assembled word (valid together with word_valid_o)
//   word_valid_o   : high in the cycle the 4th byte arrives
module byte_assembler (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic [7:0]  byte_i,
  input  logic        valid_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [1:0]  cnt_q, cnt_d;
  // Only the first three bytes are stored; the fourth completes the word
  // combinationally so the consumer can latch it on the same edge.
  logic [23:0] shift_q, shift_d;

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (clear_i) begin
      cnt_d = 2'd0;
    end else if (valid_i) begin
      cnt_d   = cnt_q + 2'd1;  // wraps to 0 after the 4th byte
      shift_d = {shift_q[15:0], byte_i};
    end
  end

  assign word_o       = {shift_q, byte_i};
  assign word_valid_o = valid_i && !clear_i && (cnt_q == 2'd3);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= 2'd0;
      shift_q <= 24'd0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/mem_loader.sv
// Boot-memory loader. Parses the host boot protocol from a byte stream and writes
// big-endian words into the program memory, holding the CPU until a jump command.
//   clk_i, rst_i             : clock, synchronous active-high reset
//   rx_data_i/rx_valid_i     : received byte stream; consumed when valid && rx_ready_o
//   rx_ready_o               : loader can take a byte
//   tx_data_o/tx_valid_o     : ack byte, held until tx_ready_i
//   tx_ready_i               : transmitter accepts the ack this cycle
//   we_o/waddr_o/wdata_o     : memory write port, one-cycle strobe per word
//   busy_o                   : high until the jump completes
//   jump_addr_o              : byte address from the last 'a' command
//   done_o                   : one-cycle pulse when the jump completes
//   err_o                    : sticky: unknown command or out-of-range write
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W   = 9,
  parameter logic [7:0]  ACK_BYTE = ACK_BYTE_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [31:0]       wdata_o,
  output logic              busy_o,
  output logic [31:0]       jump_addr_o,
  output logic              done_o,
  output logic              err_o
);

  state_e             state_q, state_d;
  logic [31:0]        ptr_q, ptr_d;
  logic [31:0]        jump_addr_q, jump_addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic               pend_q, pend_d;  // 'j' received, release CPU after its ack

  logic               consume;
  logic               asm_valid;
  logic               asm_clear;
  logic [31:0]        asm_word;
  logic               asm_word_valid;
  logic               in_range;

  assign rx_ready_o = (state_q == StIdle) || (state_q == StGetAddr) || (state_q == StGetData);
  assign consume    = rx_valid_i && rx_ready_o;
  assign asm_valid  = consume && ((state_q == StGetAddr) || (state_q == StGetData));
  // Command bytes never enter the assembler; idling also discards stale bytes.
  assign asm_clear  = (state_q == StIdle);
  assign in_range   = word_in_range(ptr_q, ADDR_W);

  byte_assembler u_byte_assembler (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (asm_clear),
    .byte_i       (rx_data_i),
    .valid_i      (asm_valid),
    .word_o       (asm_word),
    .word_valid_o (asm_word_valid)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    jump_addr_d = jump_addr_q;
    wdata_d     = wdata_q;
    waddr_d     = waddr_q;
    err_d       = err_q;
    pend_d      = pend_q;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (consume) begin
          case (rx_data_i)
            CMD_ADDR: state_d = StGetAddr;
            CMD_DATA: state_d = StGetData;
            CMD_JUMP: begin
              pend_d  = 1'b1;
              state_d = StAck;
            end
            default:  err_d = 1'b1;
          endcase
        end
      end
      StGetAddr: begin
        if (asm_word_valid) begin
          ptr_d       = asm_word;
          jump_addr_d = asm_word;
          state_d     = StAck;
        end
      end
      StGetData: begin
        if (asm_word_valid) begin
          wdata_d = asm_word;
          waddr_d = ptr_q[ADDR_W+1:2];
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (!in_range) begin
          err_d = 1'b1;
        end
        ptr_d   = ptr_q + 32'd4;  // advances even when the write was suppressed
        state_d = StAck;
      end
      StAck: begin
        if (tx_ready_i) begin
          if (pend_q) begin
            pend_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StRun;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StRun: begin
        state_d = StRun;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      ptr_q       <= 32'd0;
      jump_addr_q <= 32'd0;
      wdata_q     <= 32'd0;
      waddr_q     <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      jump_addr_q <= jump_addr_d;
      wdata_q     <= wdata_d;
      waddr_q     <= waddr_d;
      err_q       <= err_d;
      done_q      <= done_d;
      pend_q      <= pend_d;
    end
  end

  assign we_o        = (state_q == StWrite) && in_range;
  assign waddr_o     = waddr_q;
  assign wdata_o     = wdata_q;
  assign tx_valid_o  = (state_q == StAck);
  assign tx_data_o   = tx_valid_o ? ACK_BYTE : 8'h00;
  assign busy_o      = (state_q != StRun);
  assign jump_addr_o = jump_addr_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mem_loader.sv
module tb_mem_loader;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_valid_i = 1'b0;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b1;
  logic        we_o;
  logic [8:0]  waddr_o;
  logic [31:0] wdata_o;
  logic        busy_o;
  logic [31:0] jump_addr_o;
  logic        done_o;
  logic        err_o;

  mem_loader #(
    .ADDR_W   (9),
    .ACK_BYTE (8'h66)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rx_data_i   (rx_data_i),
    .rx_valid_i  (rx_valid_i),
    .rx_ready_o  (rx_ready_o),
    .tx_data_o   (tx_data_o),
    .tx_valid_o  (tx_valid_o),
    .tx_ready_i  (tx_ready_i),
    .we_o        (we_o),
    .waddr_o     (waddr_o),
    .wdata_o     (wdata_o),
    .busy_o      (busy_o),
    .jump_addr_o (jump_addr_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  int ack_cnt = 0;
  int done_cnt = 0;
  logic [8:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Observe write strobes, ack handshakes and done pulses mid-cycle.
  always @(negedge clk_i) begin
    if (we_o) begin
      wr_addr_q.push_back(waddr_o);
      wr_data_q.push_back(wdata_o);
    end
    if (tx_valid_o && tx_ready_i) begin
      ack_cnt++;
      check("ack_byte", {24'h0, tx_data_o}, 32'h66);
    end
    if (done_o) done_cnt++;
  end

  task automatic do_reset();
    @(posedge clk_i); #2;
    rst_i      = 1'b1;
    rx_valid_i = 1'b0;
    tx_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #2;
    rst_i = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    @(posedge clk_i); #2;
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (rx_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL rx_timeout: byte %h not accepted, expected acceptance", b);
    end
    @(posedge clk_i); #2;
    rx_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic wait_ack(input int base);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i); #1;
      if (ack_cnt > base) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL ack_timeout: acks %0d, expected more than %0d", ack_cnt, base);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    @(negedge clk_i);
    check({tag, "_rx_ready"}, {31'h0, rx_ready_o}, 32'h1);
    check({tag, "_tx_valid"}, {31'h0, tx_valid_o}, 32'h0);
    check({tag, "_tx_data"},  {24'h0, tx_data_o},  32'h0);
    check({tag, "_we"},       {31'h0, we_o},       32'h0);
    check({tag, "_waddr"},    {23'h0, waddr_o},    32'h0);
    check({tag, "_wdata"},    wdata_o,             32'h0);
    check({tag, "_busy"},     {31'h0, busy_o},     32'h1);
    check({tag, "_jump"},     jump_addr_o,         32'h0);
    check({tag, "_done"},     {31'h0, done_o},     32'h0);
    check({tag, "_err"},      {31'h0, err_o},      32'h0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          exp_we;
    logic [8:0]  exp_waddr;
    bit          exp_err;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int base;
    int bad;

    vecs[0] = '{addr: 32'h0000_0010, data: 32'hDEAD_BEEF, exp_we: 1'b1, exp_waddr: 9'd4,
                exp_err: 1'b0};
    vecs[1] = '{addr: 32'h0000_07FC, data: 32'h0123_4567, exp_we: 1'b1, exp_waddr: 9'd511,
                exp_err: 1'b0};
    vecs[2] = '{addr: 32'h0000_0000, data: 32'hCAFE_F00D, exp_we: 1'b1, exp_waddr: 9'd0,
                exp_err: 1'b0};
    vecs[3] = '{addr: 32'h0000_0800, data: 32'h1122_3344, exp_we: 1'b0, exp_waddr: 9'd0,
                exp_err: 1'b1};
    vecs[4] = '{addr: 32'h0000_0002, data: 32'h55AA_55AA, exp_we: 1'b0, exp_waddr: 9'd0,
                exp_err: 1'b1};

    do_reset();
    check_reset_vals("rst0");

    // Table: one 'a' + one 'd' per vector, each from a fresh reset.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      clear_log();
      base = ack_cnt;
      send_byte(8'h61);
      send_word(vecs[v].addr);
      wait_ack(base);
      check($sformatf("v%0d_jump", v), jump_addr_o, vecs[v].addr);
      base = ack_cnt;
      send_byte(8'h64);
      send_word(vecs[v].data);
      wait_ack(base);
      check($sformatf("v%0d_nwr", v), wr_addr_q.size(), vecs[v].exp_we ? 32'd1 : 32'd0);
      if (vecs[v].exp_we && wr_addr_q.size() > 0) begin
        check($sformatf("v%0d_waddr", v), {23'h0, wr_addr_q[0]}, {23'h0, vecs[v].exp_waddr});
        check($sformatf("v%0d_wdata", v), wr_data_q[0], vecs[v].data);
      end
      check($sformatf("v%0d_err", v), {31'h0, err_o}, {31'h0, vecs[v].exp_err});
      check($sformatf("v%0d_busy", v), {31'h0, busy_o}, 32'h1);
    end

    // Back-to-back writes after 'a' 0, with latency check on the first.
    do_reset();
    clear_log();
    base = ack_cnt;
    send_byte(8'h61);
    send_word(32'h0);
    wait_ack(base);
    for (int k = 0; k < 3; k++) begin
      base = ack_cnt;
      send_byte(8'h64);
      send_word(32'hA000_0000 + 32'(k) * 32'h0101_0101);
      if (k == 0) begin
        @(negedge clk_i);
        check("lat_we_n1", {31'h0, we_o}, 32'h1);
        check("lat_txv_n1", {31'h0, tx_valid_o}, 32'h0);
        @(negedge clk_i);
        check("lat_we_n2", {31'h0, we_o}, 32'h0);
        check("lat_txv_n2", {31'h0, tx_valid_o}, 32'h1);
      end
      wait_ack(base);
    end
    check("b2b_nwr", wr_addr_q.size(), 32'd3);
    if (wr_addr_q.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("b2b_waddr%0d", k), {23'h0, wr_addr_q[k]}, 32'(k));
        check($sformatf("b2b_wdata%0d", k), wr_data_q[k], 32'hA000_0000 + 32'(k) * 32'h0101_0101);
      end
    end
    check("b2b_err", {31'h0, err_o}, 32'h0);

    // Unknown command: sticky err, no ack, no write, next command still works.
    do_reset();
    clear_log();
    base = ack_cnt;
    send_byte(8'h55);
    repeat (5) @(negedge clk_i);
    check("bad_err", {31'h0, err_o}, 32'h1);
    check("bad_noack", ack_cnt, base);
    check("bad_nowr", wr_addr_q.size(), 32'd0);
    send_byte(8'h61);
    send_word(32'h0000_0020);
    wait_ack(base);
    check("bad_next_jump", jump_addr_o, 32'h0000_0020);
    check("bad_err_sticky", {31'h0, err_o}, 32'h1);

    // Reset in the middle of a 'd' command.
    do_reset();
    clear_log();
    base = ack_cnt;
    send_byte(8'h61);
    send_word(32'h0);
    wait_ack(base);
    send_byte(8'h64);
    send_byte(8'hDE);
    send_byte(8'hAD);
    do_reset();
    check_reset_vals("midrst");
    check("midrst_nowr", wr_addr_q.size(), 32'd0);
    base = ack_cnt;
    send_byte(8'h61);
    send_word(32'h0000_0008);
    wait_ack(base);
    base = ack_cnt;
    send_byte(8'h64);
    send_word(32'h1234_5678);
    wait_ack(base);
    check("midrst_nwr", wr_addr_q.size(), 32'd1);
    if (wr_addr_q.size() == 1) begin
      check("midrst_waddr", {23'h0, wr_addr_q[0]}, 32'd2);
      check("midrst_wdata", wr_data_q[0], 32'h1234_5678);
    end

    // Jump with the transmitter stalled for 20 cycles.
    do_reset();
    clear_log();
    base = ack_cnt;
    send_byte(8'h61);
    send_word(32'h0000_0100);
    wait_ack(base);
    @(posedge clk_i); #2;
    tx_ready_i = 1'b0;
    base = ack_cnt;
    send_byte(8'h6A);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (!tx_valid_o || tx_data_o != 8'h66 || !busy_o || done_o) bad++;
    end
    check("jmp_hold_bad_cycles", bad, 0);
    check("jmp_hold_noack", ack_cnt, base);
    @(posedge clk_i); #2;
    base = done_cnt;
    tx_ready_i = 1'b1;
    repeat (6) @(negedge clk_i);
    check("jmp_done_pulses", done_cnt - base, 1);
    check("jmp_busy", {31'h0, busy_o}, 32'h0);
    check("jmp_txv", {31'h0, tx_valid_o}, 32'h0);
    check("jmp_addr", jump_addr_o, 32'h0000_0100);
    @(posedge clk_i); #2;
    rx_valid_i = 1'b1;
    rx_data_i  = 8'h64;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (rx_ready_o || busy_o) bad++;
    end
    rx_valid_i = 1'b0;
    check("run_not_consumed", bad, 0);
    check("run_nowr", wr_addr_q.size(), 32'd0);
    check("run_err", {31'h0, err_o}, 32'h0);
    check("run_done_once", done_cnt - base, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Writer side of the boot memory. Takes a serial-style byte stream and assembles big-endian 32-bit words, then writes them into the 512x32 program memory through a synchronous write port.
- Reuses the command protocol the resident bootloader already speaks ('a' address, 'd' data, 'j' jump, ack 'f'), so host tools work unchanged.
- Sits between the UART receive/transmit byte interfaces and the instruction memory's write port.
- Holds the CPU via busy until a jump command is received.

Parameters:
- ADDR_W, 9, word-address width of the target memory (depth 2^ADDR_W words)
- ACK_BYTE, 8'h66, byte returned after each completed command

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data is valid; a byte is consumed when rx_valid && rx_ready
- rx_ready  out  1  loader can accept a byte
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data is valid; held until tx_ready
- tx_ready  in  1  transmitter accepts tx_data this cycle
- we  out  1  memory write strobe, one cycle per word
- waddr  out  ADDR_W  word address for the write
- wdata  out  32  word to write
- busy  out  1  high while loading; CPU held in reset/stall
- jump_addr  out  32  byte address latched by the last 'a' command
- done  out  1  one-cycle pulse when 'j' completes
- err  out  1  sticky flag for unknown command or out-of-range write; cleared only by rst

Behaviour:
- Reset values (at a clk edge with rst=1): state=IDLE, rx_ready=1, tx_valid=0, tx_data=0, we=0, waddr=0, wdata=0, busy=1, jump_addr=0, done=0, err=0, byte counter=0, address pointer=0.
- rst wins over any in-flight transfer. A partial word is discarded and no write is issued.
- States and transitions:
  - IDLE: rx_ready=1. On a consumed byte:
    - 0x61 -> GET_ADDR
    - 0x64 -> GET_DATA
    - 0x6A -> ACK, with done pending
    - anything else -> set err, stay in IDLE, no ack
  - GET_ADDR: rx_ready=1. Shift 4 bytes MSB-first into a 32-bit register. After the 4th byte: pointer <= reg, jump_addr <= reg, go to ACK.
  - GET_DATA: rx_ready=1. Shift 4 bytes MSB-first into wdata. After the 4th byte go to WRITE.
  - WRITE: rx_ready=0, exactly one cycle.
    - In range: we=1, waddr=pointer[ADDR_W+1:2].
    - Out of range (pointer[31:ADDR_W+2] != 0 or pointer[1:0] != 0): we=0 and err set.
    - pointer <= pointer + 4 regardless, 32-bit wrap at 0xFFFFFFFC -> 0.
    - Then go to ACK.
  - ACK: rx_ready=0, tx_valid=1, tx_data=ACK_BYTE.
    - On tx_ready: tx_valid <= 0.
    - If done pending: go to RUN and pulse done for that one cycle.
    - Otherwise go to IDLE.
  - RUN: busy=0, rx_ready=0. Terminal until rst.
- Latency:
  - 4th data byte consumed at edge N -> we high in cycle N+1 -> tx_valid high in cycle N+2.
  - Minimum per 'd' command: 5 byte cycles + 1 write cycle + 1 ack cycle.
- Bytes are never dropped: rx_ready=0 in WRITE/ACK/RUN, so the upstream block must hold rx_valid.
- tx_ready may be held low indefinitely. tx_valid and tx_data stay stable until accepted.
- tx_ready asserted while tx_valid=0 is ignored.
- we is never asserted in any state other than WRITE. waddr and wdata hold their values after the write.

Decomposition:
- Shared package mem_loader_pkg holds:
  - command constants CMD_ADDR=8'h61, CMD_DATA=8'h64, CMD_JUMP=8'h6A
  - default ACK_BYTE
  - state encoding (IDLE, GET_ADDR, GET_DATA, WRITE, ACK, RUN)
- One natural sub-module, byte_assembler: a 2-bit counter plus 32-bit MSB-first shift register with word_valid output. It is shared by GET_ADDR and GET_DATA.
- The loader itself is a single FSM file.

Test Plan:
- Reset, then send 61 00 00 00 10, then 64 DE AD BE EF:
  - expect ack 0x66 after each command
  - we pulse once with waddr=4, wdata=32'hDEADBEEF
  - err=0
- Three back-to-back 'd' commands after 'a' 0x00000000:
  - writes land at waddr 0, 1, 2, in order, with the correct words
  - no extra we pulses
- Send 6A with tx_ready held low 20 cycles:
  - tx_valid stays high and tx_data stays 0x66 throughout
  - on tx_ready, done pulses for exactly 1 cycle
  - busy drops to 0 and stays 0
  - further rx bytes are not consumed
- Send byte 0x55 in IDLE:
  - err rises and stays high
  - no ack, no write
  - a following 'a' command is still accepted
- Send 'a' 0x00000800 (word 512, out of range for ADDR_W=9), then 'd' 11 22 33 44:
  - no we, err=1, ack still sent
- Assert rst after the 2nd data byte of a 'd' command:
  - no write issued
  - all outputs return to reset values
  - a fresh 'a'/'d' sequence then writes correctly
